branch_predictor: RTL and testbench



---
 rtl/bpred_pkg.sv | 32 +++
 rtl/bpred_ctr_next.sv | 21 ++
 rtl/branch_predictor.sv | 114 +++++++++++
 tb/tb_branch_predictor.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch target buffer: entry layout,
// table geometry and the counter encodings loaded on allocate and reset.
package bpred_pkg;

    localparam int MAX_PC_W  = 32;
    localparam int MAX_CTR_W = 4;

    // Sized for the widest legal configuration; narrower builds zero-extend.
    typedef struct packed {
        logic                 valid;
        logic [MAX_PC_W-1:0]  tag;
        logic [MAX_PC_W-1:0]  target;
        logic [MAX_CTR_W-1:0] ctr;
    } bpred_entry_t;

    function automatic int bpred_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int bpred_tag_w(input int pc_w, input int entries);
        return pc_w - $clog2(entries) - 2;
    endfunction

    function automatic logic [MAX_CTR_W-1:0] ctr_weak_taken(input int ctr_w);
        return MAX_CTR_W'(1) << (ctr_w - 1);
    endfunction

    function automatic logic [MAX_CTR_W-1:0] ctr_weak_not_taken(input int ctr_w);
        return (MAX_CTR_W'(1) << (ctr_w - 1)) - MAX_CTR_W'(1);
    endfunction

endpackage

// File: rtl/bpred_ctr_next.sv
// Saturating up/down direction counter next-value logic.
module bpred_ctr_next #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_cur,
    input  logic             i_taken,
    output logic [CTR_W-1:0] o_next
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    always_comb begin
        o_next = i_cur;
        if (i_taken) begin
            if (i_cur != CTR_MAX) o_next = i_cur + CTR_W'(1);
        end else begin
            if (i_cur != '0) o_next = i_cur - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Define BPRED_GSHARE_EN to XOR a global history register into the index.
module branch_predictor
    import bpred_pkg::*;
#(
    parameter int PC_W    = 12,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] if_pc_i,
    output logic            pred_taken_o,
    output logic [PC_W-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [PC_W-1:0] upd_target_i,
    input  logic            upd_mispredict_i,
    output logic [31:0]     mispred_cnt_o
);

    localparam int IDX_W = bpred_idx_w(ENTRIES);
    localparam int TAG_W = bpred_tag_w(PC_W, ENTRIES);
    localparam logic [MAX_CTR_W-1:0] CTR_WT  = ctr_weak_taken(CTR_W);
    localparam logic [MAX_CTR_W-1:0] CTR_WNT = ctr_weak_not_taken(CTR_W);

    bpred_entry_t r_table [ENTRIES];
    logic [31:0]  r_mispred_cnt;

    logic [IDX_W-1:0]    w_lk_idx;
    logic [IDX_W-1:0]    w_up_idx;
    logic [TAG_W-1:0]    w_lk_tag;
    logic [TAG_W-1:0]    w_up_tag;
    bpred_entry_t        w_lk_ent;
    bpred_entry_t        w_up_ent;
    logic                w_lk_hit;
    logic                w_up_hit;
    logic [CTR_W-1:0]    w_ctr_next;

`ifdef BPRED_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;

    assign w_lk_idx = if_pc_i[IDX_W+1:2] ^ IDX_W'(r_ghr);
    assign w_up_idx = upd_pc_i[IDX_W+1:2] ^ IDX_W'(r_ghr);

    // History shifts after the update has used its pre-shift value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ghr <= '0;
        end else if (upd_valid_i) begin
            r_ghr <= GHR_W'({r_ghr, upd_taken_i});
        end
    end
`else
    assign w_lk_idx = if_pc_i[IDX_W+1:2];
    assign w_up_idx = upd_pc_i[IDX_W+1:2];
`endif

    assign w_lk_tag = if_pc_i[PC_W-1:IDX_W+2];
    assign w_up_tag = upd_pc_i[PC_W-1:IDX_W+2];

    assign w_lk_ent = r_table[w_lk_idx];
    assign w_up_ent = r_table[w_up_idx];

    assign w_lk_hit = w_lk_ent.valid && (w_lk_ent.tag == MAX_PC_W'(w_lk_tag));
    assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == MAX_PC_W'(w_up_tag));

    assign pred_taken_o  = w_lk_hit && w_lk_ent.ctr[CTR_W-1];
    assign pred_target_o = pred_taken_o ? w_lk_ent.target[PC_W-1:0]
                                        : if_pc_i + PC_W'(4);
    assign mispred_cnt_o = r_mispred_cnt;

    bpred_ctr_next #(
        .CTR_W (CTR_W)
    ) u_ctr_next (
        .i_cur   (w_up_ent.ctr[CTR_W-1:0]),
        .i_taken (upd_taken_i),
        .o_next  (w_ctr_next)
    );

    // Reset clears valid bits and counters only; tags/targets are don't-care
    // while the entry is invalid. Lookups see pre-update contents (no bypass).
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i].valid <= 1'b0;
                r_table[i].ctr   <= CTR_WNT;
            end
        end else if (upd_valid_i) begin
            if (w_up_hit) begin
                r_table[w_up_idx].ctr <= MAX_CTR_W'(w_ctr_next);
                if (upd_taken_i) begin
                    r_table[w_up_idx].target <= MAX_PC_W'(upd_target_i);
                end
            end else if (upd_taken_i) begin
                r_table[w_up_idx].valid  <= 1'b1;
                r_table[w_up_idx].tag    <= MAX_PC_W'(w_up_tag);
                r_table[w_up_idx].target <= MAX_PC_W'(upd_target_i);
                r_table[w_up_idx].ctr    <= CTR_WT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mispred_cnt <= '0;
        end else if (upd_valid_i && upd_mispredict_i) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor at default parameters.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] if_pc_i;
    logic        pred_taken_o;
    logic [11:0] pred_target_o;
    logic        upd_valid_i;
    logic [11:0] upd_pc_i;
    logic        upd_taken_i;
    logic [11:0] upd_target_i;
    logic        upd_mispredict_i;
    logic [31:0] mispred_cnt_o;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .CLK              (CLK),
        .RST              (RST),
        .if_pc_i          (if_pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_mispredict_i (upd_mispredict_i),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic [11:0] pc, input logic taken,
                       input logic [11:0] tgt, input logic mis);
        upd_valid_i      = 1'b1;
        upd_pc_i         = pc;
        upd_taken_i      = taken;
        upd_target_i     = tgt;
        upd_mispredict_i = mis;
        tick();
        upd_valid_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [11:0] pc,
                        input logic exp_taken, input logic [11:0] exp_tgt);
        if_pc_i = pc;
        #1;
        check({tag, "_taken"}, 32'(pred_taken_o), 32'(exp_taken));
        check({tag, "_target"}, 32'(pred_target_o), 32'(exp_tgt));
    endtask

    initial begin
        RST = 1'b1;
        if_pc_i = 12'h010;
        upd_valid_i = 1'b0;
        upd_pc_i = '0;
        upd_taken_i = 1'b0;
        upd_target_i = '0;
        upd_mispredict_i = 1'b0;
        tick();
        tick();
        RST = 1'b0;

        look("rst", 12'h010, 1'b0, 12'h014);
        check("rst_cnt", mispred_cnt_o, 32'd0);
        look("wrap", 12'hFFC, 1'b0, 12'h000);

        // Allocate, then walk the counter down and back up on a live entry.
        upd(12'h020, 1'b1, 12'h100, 1'b0);
        look("alloc", 12'h020, 1'b1, 12'h100);
        upd(12'h020, 1'b0, 12'h000, 1'b0);
        look("nt1", 12'h020, 1'b0, 12'h024);
        upd(12'h020, 1'b0, 12'h000, 1'b0);
        upd(12'h020, 1'b1, 12'h100, 1'b0);
        look("still_valid", 12'h020, 1'b0, 12'h024);

        // Saturation at the top of the counter range.
        for (int i = 0; i < 5; i++) upd(12'h040, 1'b1, 12'h180, 1'b0);
        upd(12'h040, 1'b0, 12'h000, 1'b0);
        look("sat_nt1", 12'h040, 1'b1, 12'h180);
        upd(12'h040, 1'b0, 12'h000, 1'b0);
        look("sat_nt2", 12'h040, 1'b0, 12'h044);

        // Aliasing: 0x020 and 0x060 share index 8.
        upd(12'h020, 1'b1, 12'h100, 1'b0);
        look("retrain", 12'h020, 1'b1, 12'h100);
        look("alias_miss", 12'h060, 1'b0, 12'h064);
        upd(12'h060, 1'b1, 12'h200, 1'b0);
        look("alias_new", 12'h060, 1'b1, 12'h200);
        look("alias_old", 12'h020, 1'b0, 12'h024);
        upd(12'h060, 1'b1, 12'h240, 1'b0);
        look("tgt_upd", 12'h060, 1'b1, 12'h240);

        // Same-cycle lookup and update: no bypass.
        if_pc_i = 12'h080;
        upd_valid_i = 1'b1;
        upd_pc_i = 12'h080;
        upd_taken_i = 1'b1;
        upd_target_i = 12'h300;
        #1;
        check("same_old_taken", 32'(pred_taken_o), 32'd0);
        check("same_old_target", 32'(pred_target_o), 32'h084);
        tick();
        upd_valid_i = 1'b0;
        look("same_new", 12'h080, 1'b1, 12'h300);

        // Misprediction counting; an unqualified pulse must not count.
        for (int i = 0; i < 3; i++) upd(12'h100, 1'b0, 12'h000, 1'b1);
        upd_mispredict_i = 1'b1;
        tick();
        upd_mispredict_i = 1'b0;
        check("mis_cnt", mispred_cnt_o, 32'd3);
        look("nt_miss_nochange", 12'h100, 1'b0, 12'h104);

        // Update presented during reset is dropped; reset clears the table.
        RST = 1'b1;
        upd_valid_i = 1'b1;
        upd_pc_i = 12'h0C0;
        upd_taken_i = 1'b1;
        upd_target_i = 12'h3C0;
        upd_mispredict_i = 1'b1;
        tick();
        RST = 1'b0;
        upd_valid_i = 1'b0;
        upd_mispredict_i = 1'b0;
        check("rst_upd_cnt", mispred_cnt_o, 32'd0);
        look("rst_upd_drop", 12'h0C0, 1'b0, 12'h0C4);
        look("rst_clear", 12'h080, 1'b0, 12'h084);

        // First update after reset starts the counter at weakly-taken.
        upd(12'h0C0, 1'b1, 12'h3C0, 1'b1);
        look("post_rst_alloc", 12'h0C0, 1'b1, 12'h3C0);
        check("post_rst_cnt", mispred_cnt_o, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
